mole_spawner: RTL

Responder side of the whack-a-mole game handshake. Answers the game FSM's ready_for_mole request with a new random mole (rng_ready pulse plus one-hot LED drive). Runs the per-mole hit window once timeout_start is raised, and reports a hit (switchx) or an expiry (timeout low) back to the game FSM. Sits between the game FSM, the board LEDs and the board slide switches.

---
 rtl/mole_spawner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - whack-a-mole responder: random mole pick, hit window, hit/expiry report.
// Optional SHRINK_WINDOW_EN: each hit shortens later windows, floored at WIN2/2.
module mole_spawner #(
    parameter int          N_MOLES  = 8,
    parameter int          TICK_DIV = 50000,
    parameter int          WIN0     = 1500,
    parameter int          WIN1     = 1000,
    parameter int          WIN2     = 600,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 level,
    input  logic                       ready_for_mole,
    input  logic                       timeout_start,
    input  logic [N_MOLES-1:0]         switches,
    output logic                       rng_ready,
    output logic [$clog2(N_MOLES)-1:0] mole_idx,
    output logic [N_MOLES-1:0]         mole_leds,
    output logic                       timeout,
    output logic                       switchx
);
    localparam int IW = $clog2(N_MOLES);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_PRESENT, S_ARMED, S_COUNT, S_HIT, S_EXPIRED
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [2:0]           retry_q, retry_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [15:0]          win_q, win_d;
    logic [N_MOLES-1:0]   sync1_q, sync2_q, prev_q;
    logic                 rng_ready_q, timeout_q, switchx_q;
    logic [N_MOLES-1:0]   leds_q, leds_d;
    logic [15:0]          base_win, load_win;
    logic                 tick, hit_edge;

    always_comb begin
        case (level)
            2'd0:    base_win = 16'(WIN0);
            2'd1:    base_win = 16'(WIN1);
            default: base_win = 16'(WIN2);
        endcase
    end

`ifdef SHRINK_WINDOW_EN
    localparam logic [15:0] FLOOR = 16'(WIN2 / 2);
    logic [15:0] shrink_q, shrink_d, step_q, step_d;
    logic [16:0] shrink_sum, floor_sum;

    always_comb begin
        floor_sum  = {1'b0, shrink_q} + {1'b0, FLOOR};
        load_win   = (floor_sum >= {1'b0, base_win}) ? FLOOR : base_win - shrink_q;
        shrink_sum = {1'b0, shrink_q} + {1'b0, step_q};
        step_d     = (state_q == S_PRESENT) ? (base_win >> 4) : step_q;
        shrink_d   = shrink_q;
        if (state_q == S_COUNT && state_d == S_HIT)
            shrink_d = shrink_sum[16] ? 16'hFFFF : shrink_sum[15:0];
        else if (state_q == S_COUNT && (state_d == S_IDLE || state_d == S_EXPIRED))
            shrink_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shrink_q <= '0;
            step_q   <= '0;
        end else begin
            shrink_q <= shrink_d;
            step_q   <= step_d;
        end
    end
`else
    assign load_win = base_win;
`endif

    // Hit is a rising edge on the synchronised switch of the active mole only.
    assign tick     = (state_q == S_COUNT) && (presc_q == PW'(TICK_DIV - 1));
    assign hit_edge = sync2_q[idx_q] & ~prev_q[idx_q];

    always_comb begin
        lfsr_d  = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = '0;
        presc_d = '0;
        win_d   = win_q;
        case (state_q)
            S_IDLE: if (ready_for_mole) state_d = S_PICK;
            S_PICK: begin
                if (lfsr_q[IW-1:0] != idx_q) begin
                    idx_d   = lfsr_q[IW-1:0];
                    state_d = S_PRESENT;
                end else if (retry_q == 3'd4) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    retry_d = retry_q + 3'd1;
                end
            end
            S_PRESENT: begin
                win_d   = load_win;
                state_d = S_ARMED;
            end
            S_ARMED: begin
                if (timeout_start)       state_d = S_COUNT;
                else if (ready_for_mole) state_d = S_PICK;
            end
            S_COUNT: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick && win_q != 16'd0) win_d = win_q - 16'd1;
                if (!timeout_start)       state_d = S_IDLE;
                else if (hit_edge)        state_d = S_HIT;
                else if (win_q == 16'd0)  state_d = S_EXPIRED;
            end
            S_HIT, S_EXPIRED: if (!timeout_start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        leds_d = (state_d == S_COUNT) ? ({{(N_MOLES-1){1'b0}}, 1'b1} << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            idx_q       <= '0;
            retry_q     <= '0;
            presc_q     <= '0;
            win_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            rng_ready_q <= 1'b0;
            leds_q      <= '0;
            timeout_q   <= 1'b1;
            switchx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            presc_q     <= presc_d;
            win_q       <= win_d;
            sync1_q     <= switches;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            rng_ready_q <= (state_d == S_PRESENT);
            leds_q      <= leds_d;
            timeout_q   <= (state_d != S_EXPIRED);
            switchx_q   <= (state_d == S_HIT);
        end
    end

    assign rng_ready = rng_ready_q;
    assign mole_idx  = idx_q;
    assign mole_leds = leds_q;
    assign timeout   = timeout_q;
    assign switchx   = switchx_q;
endmodule
